// File: rtl/spi_ram_pkg.sv
// Shared opcode encoding and width helpers for the SPI-attached burst RAM slave.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    localparam int OP_W = 2;

    // The opcode sits in the top OP_W bits of a command word; payload is right-aligned below it.
    function automatic int op_msb(input int cmd_w);
        return cmd_w - 1;
    endfunction

    function automatic int op_lsb(input int cmd_w);
        return cmd_w - OP_W;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Single-port storage with synchronous read, optional output register and a matching valid
// pipeline. Storage is never reset; only the read path is flushed by rst_n.
module ram_sp_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // First read stage: data register only loads on a read so the output holds between words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_re;
            if (i_re) begin
                r_rd_data <= r_mem[i_addr];
            end
        end
    end

    if (READ_LAT == 2) begin : g_out_reg
        logic [DATA_W-1:0] r_out_data;
        logic              r_out_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_rd_valid;
                if (r_rd_valid) begin
                    r_out_data <= r_rd_data;
                end
            end
        end

        assign o_rdata  = r_out_data;
        assign o_rvalid = r_out_valid;
    end else begin : g_no_out_reg
        assign o_rdata  = r_rd_data;
        assign o_rvalid = r_rd_valid;
    end

endmodule

// File: rtl/spi_ram_burst.sv
// RAM slave behind an SPI shifter: decodes opcode+payload words, keeps independent write and
// read pointers with optional auto-increment, returns read data and flags rejected commands.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int READ_LAT  = 1,
    parameter int AUTO_INC  = 1,
    localparam int PAY_W    = max_int(DATA_W, ADDR_W),
    localparam int CMD_W    = PAY_W + OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              err
);

    localparam int OP_MSB = op_msb(CMD_W);
    localparam int OP_LSB = op_lsb(CMD_W);

    opcode_e           w_op;
    logic [PAY_W-1:0]  w_payload;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_addr_ok;

    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_d;
    logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_d;
    logic              r_wr_armed, w_wr_armed_d;
    logic              r_rd_armed, w_rd_armed_d;
    logic              r_err, w_err_d;
    logic              w_we, w_re;
    logic [ADDR_W-1:0] w_ram_addr;

    assign w_op      = opcode_e'(rx_data[OP_MSB:OP_LSB]);
    assign w_payload = rx_data[PAY_W-1:0];
    assign w_addr    = w_payload[ADDR_W-1:0];
    assign w_wdata   = w_payload[DATA_W-1:0];
    assign w_addr_ok = (32'(w_addr) < 32'(MEM_DEPTH));

    // Wrap explicitly at MEM_DEPTH-1 so non-power-of-two depths never see an illegal pointer.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
        if (AUTO_INC == 0) begin
            return ptr;
        end
        return (32'(ptr) == 32'(MEM_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr;
        w_rd_ptr_d   = r_rd_ptr;
        w_wr_armed_d = r_wr_armed;
        w_rd_armed_d = r_rd_armed;
        w_err_d      = 1'b0;
        w_we         = 1'b0;
        w_re         = 1'b0;
        if (rx_valid) begin
            unique case (w_op)
                OP_WR_ADDR: begin
                    w_wr_armed_d = w_addr_ok;
                    w_err_d      = !w_addr_ok;
                    if (w_addr_ok) begin
                        w_wr_ptr_d = w_addr;
                    end
                end
                OP_WR_DATA: begin
                    if (r_wr_armed) begin
                        w_we       = 1'b1;
                        w_wr_ptr_d = next_ptr(r_wr_ptr);
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
                OP_RD_ADDR: begin
                    w_rd_armed_d = w_addr_ok;
                    w_err_d      = !w_addr_ok;
                    if (w_addr_ok) begin
                        w_rd_ptr_d = w_addr;
                    end
                end
                OP_RD_DATA: begin
                    if (r_rd_armed) begin
                        w_re       = 1'b1;
                        w_rd_ptr_d = next_ptr(r_rd_ptr);
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_wr_armed <= w_wr_armed_d;
            r_rd_armed <= w_rd_armed_d;
            r_err      <= w_err_d;
        end
    end

    // One command per cycle, so write and read never contend for the single port.
    assign w_ram_addr = w_we ? r_wr_ptr : r_rd_ptr;

    ram_sp_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .READ_LAT  (READ_LAT)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_re     (w_re),
        .i_addr   (w_ram_addr),
        .i_wdata  (w_wdata),
        .o_rdata  (tx_data),
        .o_rvalid (tx_valid)
    );

    assign err = r_err;

endmodule
